// File: rtl/dw_pulse_sync_multi.sv
// Multi-channel event synchroniser with per-channel pending queues and valid/ready handshake.
// Define DW_PULSE_SYNC_MULTI_DROP_CNT_EN to add the per-channel lost-event counter port drop_cnt.
module dw_pulse_sync_multi #(
    parameter int NUM_CH      = 4,
    parameter int F_SYNC_TYPE = 2,
    parameter int PULSE_MODE  = 0,
    parameter int CNT_W       = 4
) (
    input  logic                      clk_d,
    input  logic                      rst_d,
    input  logic                      init_d,
    input  logic [NUM_CH-1:0]         event_s,
    output logic [NUM_CH-1:0]         event_d,
    input  logic [NUM_CH-1:0]         event_rdy,
    output logic [NUM_CH*CNT_W-1:0]   pend_cnt,
    output logic [NUM_CH-1:0]         ovf,
    input  logic                      ovf_clr
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]       drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                           clr;
    logic [NUM_CH-1:0]              sync_s;
    logic [NUM_CH-1:0]              hist_q, hist_d;
    logic [NUM_CH-1:0]              det;
    logic [NUM_CH-1:0]              accept;
    logic [NUM_CH-1:0]              lost;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]              ovf_q, ovf_d;

    assign clr = rst_d | init_d;

    generate
        if (F_SYNC_TYPE == 0) begin : g_nosync
            assign sync_s = event_s;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_q [F_SYNC_TYPE];
            logic [NUM_CH-1:0] sync_d [F_SYNC_TYPE];

            always_comb begin
                sync_d[0] = event_s;
                for (int k = 1; k < F_SYNC_TYPE; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clk_d) begin
                for (int k = 0; k < F_SYNC_TYPE; k++) begin
                    if (clr) begin
                        sync_q[k] <= '0;
                    end else begin
                        sync_q[k] <= sync_d[k];
                    end
                end
            end

            assign sync_s = sync_q[F_SYNC_TYPE-1];
        end
    endgenerate

    assign hist_d = sync_s;

    always_comb begin
        case (PULSE_MODE)
            1:       det = sync_s & ~hist_q;
            2:       det = ~sync_s & hist_q;
            default: det = sync_s ^ hist_q;
        endcase
    end

    // Valid is decoded from registered counts only, so it never depends on event_rdy.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            event_d[i] = |cnt_q[i];
        end
        accept = event_d & event_rdy;
    end

    always_comb begin
        cnt_d = cnt_q;
        lost  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (det[i] && !accept[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    lost[i] = 1'b1;
                end
            end else if (!det[i] && accept[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        // A loss in the same cycle as a clear keeps the sticky bit set.
        ovf_d = (ovf_clr ? '0 : ovf_q) | lost;
    end

    always_ff @(posedge clk_d) begin
        if (clr) begin
            hist_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend_cnt = cnt_q;
    assign ovf      = ovf_q;

`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
    logic [NUM_CH-1:0][7:0] drop_q, drop_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            drop_d[i] = ovf_clr ? 8'd0 : drop_q[i];
            if (lost[i]) begin
                if (ovf_clr) begin
                    drop_d[i] = 8'd1;
                end else if (drop_q[i] != 8'hFF) begin
                    drop_d[i] = drop_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_d) begin
        if (clr) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_dw_pulse_sync_multi.sv
// Directed bench for dw_pulse_sync_multi: three instances cover rising, toggle and falling modes.
module tb_dw_pulse_sync_multi;

    logic clk_d = 1'b0;
    logic rst_d, init_d, ovf_clr;

    logic [3:0] m1_es, m1_rdy, m1_ev, m1_ovf;
    logic [7:0] m1_pend;
    logic [3:0] m0_es, m0_rdy, m0_ev, m0_ovf;
    logic [15:0] m0_pend;
    logic [3:0] m2_es, m2_rdy, m2_ev, m2_ovf;
    logic [7:0] m2_pend;
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
    logic [31:0] m1_drop, m0_drop, m2_drop;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_d = ~clk_d;

    dw_pulse_sync_multi #(.NUM_CH(4), .F_SYNC_TYPE(2), .PULSE_MODE(1), .CNT_W(2)) u_m1 (
        .clk_d(clk_d), .rst_d(rst_d), .init_d(init_d), .event_s(m1_es), .event_d(m1_ev),
        .event_rdy(m1_rdy), .pend_cnt(m1_pend), .ovf(m1_ovf), .ovf_clr(ovf_clr)
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
        , .drop_cnt(m1_drop)
`endif
    );

    dw_pulse_sync_multi #(.NUM_CH(4), .F_SYNC_TYPE(2), .PULSE_MODE(0), .CNT_W(4)) u_m0 (
        .clk_d(clk_d), .rst_d(rst_d), .init_d(init_d), .event_s(m0_es), .event_d(m0_ev),
        .event_rdy(m0_rdy), .pend_cnt(m0_pend), .ovf(m0_ovf), .ovf_clr(ovf_clr)
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
        , .drop_cnt(m0_drop)
`endif
    );

    dw_pulse_sync_multi #(.NUM_CH(4), .F_SYNC_TYPE(2), .PULSE_MODE(2), .CNT_W(2)) u_m2 (
        .clk_d(clk_d), .rst_d(rst_d), .init_d(init_d), .event_s(m2_es), .event_d(m2_ev),
        .event_rdy(m2_rdy), .pend_cnt(m2_pend), .ovf(m2_ovf), .ovf_clr(ovf_clr)
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
        , .drop_cnt(m2_drop)
`endif
    );

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    task automatic m1_rise(input int ch);
        m1_es[ch] = 1'b1;
        tick(); tick();
        m1_es[ch] = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        checks++;
        if (m1_pend !== 8'd0 || m1_ev !== 4'd0 || m1_ovf !== 4'd0) begin
            failures++;
            $display("FAIL reset_m1: pend=%h ev=%b ovf=%b expected all zero", m1_pend, m1_ev, m1_ovf);
        end
        checks++;
        if (m0_pend !== 16'd0 || m0_ev !== 4'd0 || m0_ovf !== 4'd0) begin
            failures++;
            $display("FAIL reset_m0: pend=%h ev=%b ovf=%b expected all zero", m0_pend, m0_ev, m0_ovf);
        end
        checks++;
        if (m2_pend !== 8'd0 || m2_ev !== 4'd0) begin
            failures++;
            $display("FAIL reset_m2: pend=%h ev=%b expected all zero", m2_pend, m2_ev);
        end
    endtask

    task automatic test_latency();
        m1_rdy[0] = 1'b1;
        m1_es[0]  = 1'b1;
        tick(); tick();
        checks++;
        if (m1_ev[0] !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: event_d[0]=%b expected 0 after edge 2", m1_ev[0]);
        end
        tick();
        checks++;
        if (m1_ev[0] !== 1'b1 || m1_pend[1:0] !== 2'd1) begin
            failures++;
            $display("FAIL latency_edge3: event_d[0]=%b pend=%0d expected 1/1", m1_ev[0], m1_pend[1:0]);
        end
        tick();
        checks++;
        if (m1_ev[0] !== 1'b0) begin
            failures++;
            $display("FAIL latency_width: event_d[0]=%b expected 0 after one accept", m1_ev[0]);
        end
        tick();
        checks++;
        if (m1_pend[1:0] !== 2'd0) begin
            failures++;
            $display("FAIL rdy_idle: pend[0]=%0d expected 0", m1_pend[1:0]);
        end
    endtask

    task automatic test_queue();
        int exp_p;
        m0_rdy = 4'b0000;
        repeat (3) begin
            m0_es[1] = ~m0_es[1];
            repeat (4) tick();
        end
        checks++;
        if (m0_pend[7:4] !== 4'd3 || m0_ev[1] !== 1'b1) begin
            failures++;
            $display("FAIL queue_fill: pend[1]=%0d ev=%b expected 3/1", m0_pend[7:4], m0_ev[1]);
        end
        m0_rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_p = (k < 3) ? 2 - k : 0;
            checks++;
            if (m0_pend[7:4] !== 4'(exp_p) || m0_ev[1] !== (exp_p != 0)) begin
                failures++;
                $display("FAIL queue_drain%0d: pend[1]=%0d ev=%b expected %0d", k, m0_pend[7:4], m0_ev[1], exp_p);
            end
        end
        m0_rdy[1] = 1'b0;
    endtask

    task automatic test_overflow();
        m1_rdy[2] = 1'b0;
        repeat (5) m1_rise(2);
        tick(); tick(); tick();
        checks++;
        if (m1_pend[5:4] !== 2'd3 || m1_ovf !== 4'b0100) begin
            failures++;
            $display("FAIL ovf_sat: pend[2]=%0d ovf=%b expected 3/0100", m1_pend[5:4], m1_ovf);
        end
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
        checks++;
        if (m1_drop[23:16] !== 8'd2) begin
            failures++;
            $display("FAIL drop_cnt: drop[2]=%0d expected 2", m1_drop[23:16]);
        end
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (m1_ovf !== 4'b0000 || m1_pend[5:4] !== 2'd3) begin
            failures++;
            $display("FAIL ovf_clr: ovf=%b pend[2]=%0d expected 0000/3", m1_ovf, m1_pend[5:4]);
        end
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
        checks++;
        if (m1_drop[23:16] !== 8'd0) begin
            failures++;
            $display("FAIL drop_clr: drop[2]=%0d expected 0", m1_drop[23:16]);
        end
`endif
    endtask

    task automatic test_det_accept();
        m1_es[2] = 1'b1;
        tick(); tick();
        m1_rdy[2] = 1'b1;
        tick();
        m1_rdy[2] = 1'b0;
        checks++;
        if (m1_pend[5:4] !== 2'd3 || m1_ovf[2] !== 1'b0) begin
            failures++;
            $display("FAIL det_accept_max: pend[2]=%0d ovf=%b expected 3/0", m1_pend[5:4], m1_ovf[2]);
        end
        m1_es[2] = 1'b0;
        tick(); tick(); tick();
        m1_es[2] = 1'b1;
        tick(); tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (m1_ovf[2] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins: ovf[2]=%b expected 1", m1_ovf[2]);
        end
`ifdef DW_PULSE_SYNC_MULTI_DROP_CNT_EN
        checks++;
        if (m1_drop[23:16] !== 8'd1) begin
            failures++;
            $display("FAIL drop_inc_wins: drop[2]=%0d expected 1", m1_drop[23:16]);
        end
`endif
        m1_es[2] = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick(); tick();
    endtask

    task automatic test_init();
        m1_rdy[3] = 1'b0;
        m1_rise(3);
        m1_es[3] = 1'b1;
        repeat (4) tick();
        checks++;
        if (m1_pend[7:6] !== 2'd2) begin
            failures++;
            $display("FAIL init_setup: pend[3]=%0d expected 2", m1_pend[7:6]);
        end
        init_d = 1'b1;
        tick();
        init_d = 1'b0;
        checks++;
        if (m1_pend !== 8'd0 || m1_ovf !== 4'd0 || m1_ev !== 4'd0) begin
            failures++;
            $display("FAIL init_clear: pend=%h ovf=%b ev=%b expected all zero", m1_pend, m1_ovf, m1_ev);
        end
        tick(); tick();
        checks++;
        if (m1_pend[7:6] !== 2'd0) begin
            failures++;
            $display("FAIL init_resync_early: pend[3]=%0d expected 0", m1_pend[7:6]);
        end
        tick();
        checks++;
        if (m1_pend[7:6] !== 2'd1 || m1_ev[3] !== 1'b1) begin
            failures++;
            $display("FAIL init_new_event: pend[3]=%0d ev=%b expected 1/1", m1_pend[7:6], m1_ev[3]);
        end
        repeat (3) tick();
        checks++;
        if (m1_pend[7:6] !== 2'd1) begin
            failures++;
            $display("FAIL init_single: pend[3]=%0d expected 1", m1_pend[7:6]);
        end
    endtask

    task automatic test_mode2();
        m2_rdy   = 4'b0000;
        m2_es[0] = 1'b1;
        tick();
        rst_d = 1'b1;
        tick(); tick();
        rst_d = 1'b0;
        repeat (6) tick();
        checks++;
        if (m2_pend[1:0] !== 2'd0 || m2_ev[0] !== 1'b0) begin
            failures++;
            $display("FAIL fall_held_high: pend[0]=%0d ev=%b expected 0/0", m2_pend[1:0], m2_ev[0]);
        end
        m2_es[0] = 1'b0;
        tick(); tick();
        checks++;
        if (m2_pend[1:0] !== 2'd0) begin
            failures++;
            $display("FAIL fall_early: pend[0]=%0d expected 0", m2_pend[1:0]);
        end
        tick();
        checks++;
        if (m2_pend[1:0] !== 2'd1 || m2_ev[0] !== 1'b1) begin
            failures++;
            $display("FAIL fall_event: pend[0]=%0d ev=%b expected 1/1", m2_pend[1:0], m2_ev[0]);
        end
    endtask

    initial begin
        rst_d   = 1'b1;
        init_d  = 1'b0;
        ovf_clr = 1'b0;
        m1_es = '0; m1_rdy = '0;
        m0_es = '0; m0_rdy = '0;
        m2_es = '0; m2_rdy = '0;
        tick(); tick(); tick();
        test_reset();
        rst_d = 1'b0;
        tick();
        test_latency();
        test_queue();
        test_overflow();
        test_det_accept();
        test_init();
        test_mode2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
